pipe_mux_rs: RTL



---
 rtl/pipe_mux_rs.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipe_mux_rs.sv
// pipe_mux_rs: registered NUM_IN:1 word mux, valid/ready both sides, one-cycle latency, 2-entry skid.
// in_ready is a flop output (never depends on out_ready); optional MUX_SEL_ERR_EN adds sticky sel_err.
module pipe_mux_rs #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef MUX_SEL_ERR_EN
   ,
   output logic                    sel_err
`endif
);

   if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
      $error("pipe_mux_rs: NUM_IN must be in 2..16");
   end
   if (SEL_W != $clog2(NUM_IN)) begin : g_bad_sel_w
      $error("pipe_mux_rs: SEL_W is derived from NUM_IN and must not be overridden");
   end

   typedef struct packed {
      logic [WIDTH-1:0] dat;
      logic [SEL_W-1:0] sel;
   } beat_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t state_q, state_d;
   beat_t  main_q, main_d;
   beat_t  skid_q, skid_d;
   beat_t  in_beat;
   logic   accept;
   logic   xfer;

   // Compare-and-pick rather than a variable part-select so selects past NUM_IN fall out as zero.
   always_comb begin
      in_beat.dat = '0;
      in_beat.sel = in_sel;
      for (int k = 0; k < NUM_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            in_beat.dat = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign accept = in_valid & in_ready;
   assign xfer   = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_d  = in_beat;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && xfer) begin
               main_d = in_beat;
            end else if (accept) begin
               skid_d  = in_beat;
               state_d = ST_FULL;
            end else if (xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (xfer) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (state_q != ST_EMPTY);
      in_ready  = (state_q != ST_FULL);
      out_data  = main_q.dat;
      out_sel   = main_q.sel;
   end

`ifdef MUX_SEL_ERR_EN
   logic sel_oor;
   logic sel_err_q, sel_err_d;

   always_comb begin
      sel_oor = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            sel_oor = 1'b0;
         end
      end
   end

   always_comb begin
      sel_err_d = sel_err_q | (accept & sel_oor);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= sel_err_d;
      end
   end

   assign sel_err = sel_err_q;
`endif

   a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));

endmodule
